out_wrapper_controller: RTL and testbench
=========================================

Name: out_wrapper_controller

Overview:
- Output-side wrapper for the IMC macro.
- Captures the full result vector when the IMC signals completion.
- Serializes the vector one word at a time to the downstream consumer over a valid/ready handshake.
- Tells the IMC when it may deliver the next result, and flags results that arrive while a frame is still being sent.

Parameters:
- DATA_W, 8, width of one output word.
- N_OUT, 4, number of words per IMC result (legal range ≥ 2).

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rstn_i  input  1  asynchronous active-low reset
- imc_done_i  input  1  one-cycle pulse: IMC result valid on imc_result_i this cycle
- imc_result_i  input  N_OUT*DATA_W  IMC result; word k = bits [k*DATA_W +: DATA_W]
- out_ready_o  output  1  wrapper can accept a new result (high only in IDLE)
- data_valid_o  output  1  data_o holds a valid word
- data_o  output  DATA_W  current output word; 0 when data_valid_o = 0
- data_ready_i  input  1  downstream accepts data_o this cycle
- word_idx_o  output  clog2(N_OUT)  index of word on data_o
- frame_done_o  output  1  one-cycle pulse after the last word is accepted
- overflow_o  output  1  sticky: imc_done_i seen while not in IDLE

Behaviour:
- Clock and reset: single clock clk_i. rstn_i is asynchronous, active-low; every register clears immediately on assertion.
- Reset values:
  - state = IDLE, word index = 0, result register = 0, overflow_o = 0.
  - Outputs: out_ready_o = 1, data_valid_o = 0, data_o = 0, word_idx_o = 0, frame_done_o = 0.
- State IDLE:
  - out_ready_o = 1.
  - On imc_done_i = 1: register imc_result_i, clear the word index, go to SEND.
- State SEND:
  - data_valid_o = 1; data_o = stored word[idx]; word_idx_o = idx.
  - Transfer occurs when data_valid_o and data_ready_i are both 1.
  - On transfer with idx < N_OUT-1: idx increments, stay in SEND.
  - On transfer with idx = N_OUT-1: go to DONE.
  - With data_ready_i = 0: data_o, word_idx_o and data_valid_o hold stable indefinitely; no timeout.
- State DONE:
  - frame_done_o = 1 for exactly one cycle, data_valid_o = 0, then go to IDLE.
- Word order: word 0 (LSBs of imc_result_i) first, word N_OUT-1 last.
- Latency and throughput:
  - imc_done_i sampled at edge t → word 0 valid after edge t.
  - With data_ready_i held high: one word per cycle.
  - frame_done_o asserts the cycle after the last transfer; out_ready_o reasserts one cycle later.
  - Minimum frame period is N_OUT+2 cycles.
- Outputs are decoded from registered state only. data_o is a mux of the result register gated by data_valid_o. out_ready_o does not depend combinationally on imc_done_i.
- Result register is written only in IDLE on imc_done_i. It is not modified during SEND or DONE.
- imc_done_i in SEND or DONE:
  - The result is dropped.
  - overflow_o sets and stays 1 until reset.
  - The current frame is unaffected.
- data_ready_i while data_valid_o = 0 (IDLE or DONE): ignored, no state change.
- Index counter: unsigned, clog2(N_OUT) bits. Never exceeds N_OUT-1; cleared on entry to SEND.
- Reset mid-frame: the frame is discarded, all outputs return to reset values, and no frame_done_o pulse is generated.
- Illegal or unused state encodings go to IDLE on the next edge.

Test Plan:
1. Reset, then imc_done_i pulse with imc_result_i = 0x44332211, data_ready_i held 1 → data_o = 0x11, 0x22, 0x33, 0x44 on four consecutive cycles with word_idx_o = 0..3; frame_done_o pulses the following cycle; out_ready_o returns to 1 one cycle later; overflow_o = 0.
2. Result 0xDDCCBBAA with data_ready_i toggling 0,1,0,0,1,1,0,1 → exactly four transfers, in order 0xAA, 0xBB, 0xCC, 0xDD; data_o stable during every stall; frame_done_o fires once.
3. Second imc_done_i pulse (result 0x01020304) two cycles into the frame of 0x44332211 → frame still outputs 0x11..0x44; overflow_o = 1 and stays 1 after the frame; out_ready_o = 0 throughout SEND.
4. Two frames back-to-back: 0x44332211, then a new imc_done_i on the first cycle out_ready_o = 1, with result 0x88776655 → second frame outputs 0x55..0x88; overflow_o = 0.
5. rstn_i asserted asynchronously while word_idx_o = 2 → all outputs return to reset values immediately; no frame_done_o pulse; a new frame afterwards starts at word 0.
6. data_ready_i = 1 in IDLE with no imc_done_i for 10 cycles → data_valid_o = 0, data_o = 0, no frame_done_o pulse, state remains IDLE.

Source files
------------

// File: rtl/out_wrapper_controller.sv
// Output-side wrapper for the IMC macro: captures a completed result vector and
// streams it out one word at a time over a valid/ready handshake.
module out_wrapper_controller #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    imc_done_i,
  input  logic [N_OUT*DATA_W-1:0] imc_result_i,
  output logic                    out_ready_o,
  output logic                    data_valid_o,
  output logic [DATA_W-1:0]       data_o,
  input  logic                    data_ready_i,
  output logic [IDX_W-1:0]        word_idx_o,
  output logic                    frame_done_o,
  output logic                    overflow_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              overflow_reg, overflow_next;
  logic              capture;
  logic [DATA_W-1:0] result_reg [N_OUT];

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      overflow_reg <= overflow_next;
    end
  end

  // Next-state logic; the index only advances on an accepted word
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (imc_done_i) begin
          state_next = ST_SEND;
          idx_next   = '0;
          capture    = 1'b1;
        end
      end
      ST_SEND: begin
        if (data_ready_i) begin
          if (idx_reg == LAST_IDX) begin
            state_next = ST_DONE;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Results arriving outside IDLE are dropped and remembered until reset
  always_comb begin
    overflow_next = overflow_reg | (imc_done_i && (state_reg != ST_IDLE));
  end

  // One register per word so the capture slices map directly onto storage
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_word
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        result_reg[gi] <= '0;
      end else if (capture) begin
        result_reg[gi] <= imc_result_i[gi*DATA_W +: DATA_W];
      end
    end
  end

  // Outputs decode registered state only
  always_comb begin
    out_ready_o  = (state_reg == ST_IDLE);
    data_valid_o = (state_reg == ST_SEND);
    frame_done_o = (state_reg == ST_DONE);
    overflow_o   = overflow_reg;
    word_idx_o   = '0;
    data_o       = '0;
    if (state_reg == ST_SEND) begin
      word_idx_o = idx_reg;
      data_o     = result_reg[idx_reg];
    end
  end

endmodule

// File: tb/tb_out_wrapper_controller.sv
// Directed bench for out_wrapper_controller: framing, stalls, overflow,
// back-to-back frames, asynchronous reset mid-frame and idle behaviour.
module tb_out_wrapper_controller;

  localparam int DATA_W = 8;
  localparam int N_OUT  = 4;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        imc_done_i;
  logic [31:0] imc_result_i;
  logic        out_ready_o;
  logic        data_valid_o;
  logic [7:0]  data_o;
  logic        data_ready_i;
  logic [1:0]  word_idx_o;
  logic        frame_done_o;
  logic        overflow_o;

  int checks = 0;
  int errors = 0;

  out_wrapper_controller #(.DATA_W(DATA_W), .N_OUT(N_OUT)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .imc_done_i   (imc_done_i),
    .imc_result_i (imc_result_i),
    .out_ready_o  (out_ready_o),
    .data_valid_o (data_valid_o),
    .data_o       (data_o),
    .data_ready_i (data_ready_i),
    .word_idx_o   (word_idx_o),
    .frame_done_o (frame_done_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_out_ready"}, 32'(out_ready_o), 32'd1);
    check_val({tag, "_valid"}, 32'(data_valid_o), 32'd0);
    check_val({tag, "_data"}, 32'(data_o), 32'd0);
    check_val({tag, "_idx"}, 32'(word_idx_o), 32'd0);
    check_val({tag, "_frame_done"}, 32'(frame_done_o), 32'd0);
    check_val({tag, "_overflow"}, 32'(overflow_o), 32'd0);
  endtask

  task automatic start_frame(input logic [31:0] val);
    check_val("start_out_ready", 32'(out_ready_o), 32'd1);
    imc_done_i   = 1'b1;
    imc_result_i = val;
    tick();
    imc_done_i   = 1'b0;
    imc_result_i = 32'h0;
  endtask

  // Streams a frame with data_ready held high; exp packs the words LSB first
  task automatic full_speed_frame(input string tag, input logic [31:0] exp);
    logic [31:0] w;
    for (int k = 0; k < N_OUT; k++) begin
      w = (exp >> (8 * k)) & 32'hFF;
      check_val({tag, "_valid"}, 32'(data_valid_o), 32'd1);
      check_val({tag, "_data"}, 32'(data_o), w);
      check_val({tag, "_idx"}, 32'(word_idx_o), 32'(k));
      check_val({tag, "_ready_low"}, 32'(out_ready_o), 32'd0);
      $display("%s word %0d data=0x%02h", tag, k, data_o);
      tick();
    end
    check_val({tag, "_frame_done"}, 32'(frame_done_o), 32'd1);
    check_val({tag, "_done_valid"}, 32'(data_valid_o), 32'd0);
    check_val({tag, "_done_ready"}, 32'(out_ready_o), 32'd0);
    tick();
    check_val({tag, "_fd_cleared"}, 32'(frame_done_o), 32'd0);
    check_val({tag, "_ready_back"}, 32'(out_ready_o), 32'd1);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    tick();
    tick();
    rstn_i = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0]  stall_pat;
    logic [31:0] exp_words [4];
    logic [7:0]  prev_data;
    logic        prev_stall;
    int          xfers;
    int          fd_count;

    rstn_i       = 1'b0;
    imc_done_i   = 1'b0;
    imc_result_i = 32'h0;
    data_ready_i = 1'b0;
    #2;
    check_reset_outputs("rst_async");
    tick();
    check_reset_outputs("rst_held");
    rstn_i = 1'b1;
    tick();
    check_reset_outputs("rst_released");

    // 1: basic frame at full rate
    data_ready_i = 1'b1;
    start_frame(32'h44332211);
    full_speed_frame("t1", 32'h44332211);
    check_val("t1_overflow", 32'(overflow_o), 32'd0);

    // 2: stalls from a fixed ready pattern (applied LSB-first per cycle 0,1,0,0,1,1,0,1)
    stall_pat    = 8'b1011_0010;
    exp_words[0] = 32'hAA;
    exp_words[1] = 32'hBB;
    exp_words[2] = 32'hCC;
    exp_words[3] = 32'hDD;
    data_ready_i = 1'b0;
    start_frame(32'hDDCCBBAA);
    xfers      = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h0;
    for (int c = 0; c < 8; c++) begin
      data_ready_i = stall_pat[c];
      check_val("t2_valid", 32'(data_valid_o), 32'd1);
      check_val("t2_data", 32'(data_o), exp_words[xfers]);
      check_val("t2_idx", 32'(word_idx_o), 32'(xfers));
      if (prev_stall) check_val("t2_stall_stable", 32'(data_o), 32'(prev_data));
      check_val("t2_no_frame_done", 32'(frame_done_o), 32'd0);
      prev_stall = !data_ready_i;
      prev_data  = data_o;
      if (data_ready_i) begin
        $display("t2 cycle %0d transfer %0d data=0x%02h", c, xfers, data_o);
        xfers++;
      end
      tick();
    end
    check_val("t2_xfers", 32'(xfers), 32'd4);
    data_ready_i = 1'b0;
    fd_count = 0;
    for (int c = 0; c < 4; c++) begin
      if (frame_done_o) fd_count++;
      check_val("t2_after_valid", 32'(data_valid_o), 32'd0);
      tick();
    end
    check_val("t2_fd_count", 32'(fd_count), 32'd1);
    check_val("t2_overflow", 32'(overflow_o), 32'd0);

    // 3: result arriving mid-frame is dropped and flagged
    data_ready_i = 1'b1;
    start_frame(32'h44332211);
    for (int k = 0; k < N_OUT; k++) begin
      check_val("t3_data", 32'(data_o), (32'h44332211 >> (8 * k)) & 32'hFF);
      check_val("t3_idx", 32'(word_idx_o), 32'(k));
      check_val("t3_ready_low", 32'(out_ready_o), 32'd0);
      if (k == 1) begin
        imc_done_i   = 1'b1;
        imc_result_i = 32'h01020304;
      end
      tick();
      imc_done_i   = 1'b0;
      imc_result_i = 32'h0;
      $display("t3 after word %0d overflow=%0d", k, overflow_o);
    end
    check_val("t3_frame_done", 32'(frame_done_o), 32'd1);
    check_val("t3_overflow_set", 32'(overflow_o), 32'd1);
    tick();
    check_val("t3_ready_back", 32'(out_ready_o), 32'd1);
    tick();
    tick();
    check_val("t3_overflow_sticky", 32'(overflow_o), 32'd1);
    check_val("t3_idle_valid", 32'(data_valid_o), 32'd0);
    do_reset();
    check_val("t3_overflow_cleared", 32'(overflow_o), 32'd0);

    // 4: back-to-back frames
    data_ready_i = 1'b1;
    start_frame(32'h44332211);
    full_speed_frame("t4a", 32'h44332211);
    start_frame(32'h88776655);
    full_speed_frame("t4b", 32'h88776655);
    check_val("t4_overflow", 32'(overflow_o), 32'd0);

    // 5: asynchronous reset mid-frame
    start_frame(32'h44332211);
    tick();
    tick();
    check_val("t5_idx_before", 32'(word_idx_o), 32'd2);
    check_val("t5_data_before", 32'(data_o), 32'h33);
    #2;
    rstn_i = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    tick();
    tick();
    rstn_i = 1'b1;
    fd_count = 0;
    for (int c = 0; c < 4; c++) begin
      if (frame_done_o) fd_count++;
      tick();
    end
    check_val("t5_no_fd", 32'(fd_count), 32'd0);
    check_reset_outputs("t5_after");
    start_frame(32'hA1B2C3D4);
    full_speed_frame("t5_new", 32'hA1B2C3D4);

    // 6: ready high while idle does nothing
    data_ready_i = 1'b1;
    fd_count = 0;
    for (int c = 0; c < 10; c++) begin
      check_val("t6_valid", 32'(data_valid_o), 32'd0);
      check_val("t6_data", 32'(data_o), 32'd0);
      check_val("t6_ready", 32'(out_ready_o), 32'd1);
      if (frame_done_o) fd_count++;
      tick();
    end
    check_val("t6_no_fd", 32'(fd_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
